// File: rtl/mem_req_queue.sv
// In-order load/store request queue feeding a memory unit with one operation in flight.
// Optional store-to-load forwarding of the last issued store is enabled by defining STORE_FWD_EN.
module mem_req_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_isld,
  input  logic        in_isst,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_addr,
  input  logic [15:0] in_data,
  output logic        mem_isld,
  output logic        mem_isst,
  output logic [15:0] mem_instr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_op2,
  input  logic [15:0] mem_ldresult,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [18:0] wb_rdval,
  output logic [3:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LAT_W = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned RD_W  = 3;
  localparam int unsigned WB_W  = DW + RD_W;
  localparam int unsigned FA_W  = 5;

  typedef struct packed {
    logic          isld;
    logic [DW-1:0] instr;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  entry_t             fifo_q [DEPTH];
  entry_t             head_c;
  entry_t             in_entry_c;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               push_c, pop_c, lat_done_c, fwd_hit_c;
  logic [DW-1:0]      fwd_data_c, ld_data_c;

  logic               in_ready_q, in_ready_d;
  logic               mem_isld_q, mem_isld_d;
  logic               mem_isst_q, mem_isst_d;
  logic [DW-1:0]      mem_instr_q, mem_instr_d;
  logic [DW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_op2_q, mem_op2_d;
  logic               wb_valid_q, wb_valid_d;
  logic [WB_W-1:0]    wb_rdval_q, wb_rdval_d;
  logic               issue_n;

  // A request flagged as both load and store is treated as a load.
  assign in_entry_c = '{isld: in_isld, instr: in_instr, addr: in_addr, data: in_data};
  assign head_c     = fifo_q[head_q];
  assign push_c     = in_valid && in_ready_q && (in_isld || in_isst);
  assign lat_done_c = (state_q == S_WAIT) && (lat_q <= LAT_W'(1));
  assign pop_c      = ((state_q == S_ISSUE) && (!head_c.isld || fwd_hit_c)) || lat_done_c;
  assign ld_data_c  = (state_q == S_ISSUE) ? fwd_data_c : mem_ldresult;

  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[tail_q] <= in_entry_c;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_c) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop_c) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      lat_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      lat_q   <= lat_d;
    end
  end

`ifdef STORE_FWD_EN
  logic            fwd_valid_q;
  logic [FA_W-1:0] fwd_addr_q;
  logic [DW-1:0]   fwd_data_q;

  // Remember the most recently issued store for forwarding to later loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else if ((state_q == S_ISSUE) && !head_c.isld) begin
      fwd_valid_q <= 1'b1;
      fwd_addr_q  <= head_c.addr[FA_W-1:0];
      fwd_data_q  <= head_c.data;
    end
  end

  assign fwd_hit_c  = fwd_valid_q && head_c.isld && (head_c.addr[FA_W-1:0] == fwd_addr_q);
  assign fwd_data_c = fwd_data_q;
`else
  assign fwd_hit_c  = 1'b0;
  assign fwd_data_c = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!head_c.isld) begin
          state_d = S_IDLE;
        end else if (fwd_hit_c) begin
          state_d = S_WB;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_done_c) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    issue_n     = (state_d == S_ISSUE);
    mem_isld_d  = issue_n && head_c.isld && !fwd_hit_c;
    mem_isst_d  = issue_n && !head_c.isld;
    mem_instr_d = issue_n ? head_c.instr : '0;
    mem_addr_d  = issue_n ? head_c.addr  : '0;
    mem_op2_d   = issue_n ? head_c.data  : '0;
    wb_valid_d  = (state_d == S_WB);
    in_ready_d  = (count_d < CNT_W'(DEPTH));
    lat_d       = lat_q;
    wb_rdval_d  = '0;
    if ((state_q == S_ISSUE) && (state_d == S_WAIT)) begin
      lat_d = LAT_W'(LD_LAT);
    end else if (state_q == S_WAIT) begin
      lat_d = lat_q - LAT_W'(1);
    end
    if (state_d == S_WB) begin
      wb_rdval_d = (state_q == S_WB) ? wb_rdval_q : {ld_data_c, head_c.instr[10:8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      mem_isld_q  <= 1'b0;
      mem_isst_q  <= 1'b0;
      mem_instr_q <= '0;
      mem_addr_q  <= '0;
      mem_op2_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_rdval_q  <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      mem_isld_q  <= mem_isld_d;
      mem_isst_q  <= mem_isst_d;
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      mem_op2_q   <= mem_op2_d;
      wb_valid_q  <= wb_valid_d;
      wb_rdval_q  <= wb_rdval_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_isld  = mem_isld_q;
  assign mem_isst  = mem_isst_q;
  assign mem_instr = mem_instr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_op2   = mem_op2_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rdval  = wb_rdval_q;
  assign count     = count_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: cycle-by-cycle vector table plus corner-case sequences.
module tb_mem_req_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_isld, in_isst;
  logic [15:0] in_instr, in_addr, in_data;
  logic        mem_isld, mem_isst;
  logic [15:0] mem_instr, mem_addr, mem_op2, mem_ldresult;
  logic        wb_valid, wb_ready;
  logic [18:0] wb_rdval;
  logic [3:0]  count;

  always #5 clk = ~clk;

  mem_req_queue #(.DEPTH(DEPTH), .LD_LAT(LD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_isld(in_isld), .in_isst(in_isst),
    .in_instr(in_instr), .in_addr(in_addr), .in_data(in_data),
    .mem_isld(mem_isld), .mem_isst(mem_isst), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_op2(mem_op2), .mem_ldresult(mem_ldresult),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdval(wb_rdval), .count(count)
  );

  typedef struct {
    logic        v, ld, st;
    logic [15:0] instr, addr, data;
    logic        e_rdy, e_ld, e_st;
    logic [15:0] e_instr, e_addr, e_op2;
    logic        e_wbv;
    logic [18:0] e_rdval;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t        vecs [15];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        log_en  = 1'b0;
  logic [15:0] issued_q [$];

  always @(negedge clk) begin
    if (log_en && (mem_isld || mem_isst)) issued_q.push_back(mem_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic v, ld, st, input logic [15:0] instr, addr, data,
                              input logic e_rdy, e_ld, e_st, input logic [15:0] e_instr, e_addr, e_op2,
                              input logic e_wbv, input logic [18:0] e_rdval, input logic [3:0] e_cnt);
    vec_t r;
    r.v = v; r.ld = ld; r.st = st; r.instr = instr; r.addr = addr; r.data = data;
    r.e_rdy = e_rdy; r.e_ld = e_ld; r.e_st = e_st; r.e_instr = e_instr; r.e_addr = e_addr;
    r.e_op2 = e_op2; r.e_wbv = e_wbv; r.e_rdval = e_rdval; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic ld, input logic st, input logic [15:0] instr,
                      input logic [15:0] addr, input logic [15:0] data);
    in_valid = 1'b1; in_isld = ld; in_isst = st;
    in_instr = instr; in_addr = addr; in_data = data;
    step();
    in_valid = 1'b0; in_isld = 1'b0; in_isst = 1'b0;
  endtask

  initial begin
    int          t_iss, t_wb, g;
    logic        saw_ld, seen_wb, accepted;
    logic [18:0] rdval;
    logic [15:0] exp_addr [9];

    rst_n = 1'b0; in_valid = 1'b0; in_isld = 1'b0; in_isst = 1'b0;
    in_instr = '0; in_addr = '0; in_data = '0;
    mem_ldresult = 16'hBEEF; wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.wb_valid", 32'(wb_valid), 32'd0);
    chk("reset.mem_isld", 32'(mem_isld), 32'd0);
    rst_n = 1'b1;
    step();

    // v ld st instr addr data | rdy ld st instr addr op2 wbv rdval cnt
    vecs[0]  = mk(1,1,0,16'h0500,16'h0003,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000, 0,19'h0,     4'd1);
    vecs[1]  = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,1,0,16'h0500,16'h0003,16'h0000, 0,19'h0,     4'd1);
    vecs[2]  = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000, 0,19'h0,     4'd1);
    vecs[3]  = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000, 1,19'h5F77D, 4'd0);
    vecs[4]  = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000, 0,19'h0,     4'd0);
    vecs[5]  = mk(1,0,1,16'h0000,16'h0007,16'h1234, 1,0,0,16'h0000,16'h0000,16'h0000, 0,19'h0,     4'd1);
    vecs[6]  = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,0,1,16'h0000,16'h0007,16'h1234, 0,19'h0,     4'd1);
    vecs[7]  = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000, 0,19'h0,     4'd0);
    vecs[8]  = mk(1,0,0,16'h0700,16'h0009,16'h5555, 1,0,0,16'h0000,16'h0000,16'h0000, 0,19'h0,     4'd0);
    vecs[9]  = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000, 0,19'h0,     4'd0);
    vecs[10] = mk(1,1,1,16'h0100,16'h0011,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000, 0,19'h0,     4'd1);
    vecs[11] = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,1,0,16'h0100,16'h0011,16'h0000, 0,19'h0,     4'd1);
    vecs[12] = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000, 0,19'h0,     4'd1);
    vecs[13] = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000, 1,19'h5F779, 4'd0);
    vecs[14] = mk(0,0,0,16'h0000,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000, 0,19'h0,     4'd0);

    for (int i = 0; i < 15; i++) begin
      in_valid = vecs[i].v; in_isld = vecs[i].ld; in_isst = vecs[i].st;
      in_instr = vecs[i].instr; in_addr = vecs[i].addr; in_data = vecs[i].data;
      step();
      chk($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d.mem_isld", i),  32'(mem_isld),  32'(vecs[i].e_ld));
      chk($sformatf("vec%0d.mem_isst", i),  32'(mem_isst),  32'(vecs[i].e_st));
      chk($sformatf("vec%0d.mem_instr", i), 32'(mem_instr), 32'(vecs[i].e_instr));
      chk($sformatf("vec%0d.mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_addr));
      chk($sformatf("vec%0d.mem_op2", i),   32'(mem_op2),   32'(vecs[i].e_op2));
      chk($sformatf("vec%0d.wb_valid", i),  32'(wb_valid),  32'(vecs[i].e_wbv));
      chk($sformatf("vec%0d.wb_rdval", i),  32'(wb_rdval),  32'(vecs[i].e_rdval));
      chk($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].e_cnt));
    end
    in_valid = 1'b0; in_isld = 1'b0; in_isst = 1'b0;

    // Store then load to the same address: forwarded or issued to memory.
    push(1'b0, 1'b1, 16'h0000, 16'h0007, 16'h1234);
    push(1'b1, 1'b0, 16'h0600, 16'h0007, 16'h0000);
    t_iss = -1; t_wb = -1; saw_ld = 1'b0; rdval = '0;
    for (int t = 0; t < 20; t++) begin
      if (mem_instr == 16'h0600) begin
        t_iss = t; saw_ld = mem_isld;
      end
      if (wb_valid) begin
        t_wb = t; rdval = wb_rdval;
        break;
      end
      step();
    end
    chk("fwd.wb_seen", 32'(t_wb >= 0), 32'd1);
    chk("fwd.issue_seen", 32'(t_iss >= 0), 32'd1);
`ifdef STORE_FWD_EN
    chk("fwd.mem_isld", 32'(saw_ld), 32'd0);
    chk("fwd.rdval", 32'(rdval), 32'h91A6);
    chk("fwd.latency", 32'(t_wb - t_iss), 32'd1);
`else
    chk("fwd.mem_isld", 32'(saw_ld), 32'd1);
    chk("fwd.rdval", 32'(rdval), 32'h5F77E);
    chk("fwd.latency", 32'(t_wb - t_iss), 32'(LD_LAT + 1));
`endif
    step();

    // Writeback stall fills the queue; fifth request must wait for a pop.
    wb_ready = 1'b0;
    push(1'b1, 1'b0, 16'h0300, 16'h0020, 16'h0000);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 16'h0000, 16'(16'h0030 + i), 16'(16'hA000 + i));
    chk("full.count", 32'(count), 32'd4);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.wb_valid", 32'(wb_valid), 32'd1);
    in_valid = 1'b1; in_isld = 1'b0; in_isst = 1'b1; in_addr = 16'h0034; in_data = 16'hA004;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d.wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("stall%0d.wb_rdval", i), 32'(wb_rdval), 32'h5F77B);
      chk($sformatf("stall%0d.mem_isst", i), 32'(mem_isst), 32'd0);
      chk($sformatf("stall%0d.count", i), 32'(count), 32'd4);
    end
    wb_ready = 1'b1;
    step();
    chk("release.wb_valid", 32'(wb_valid), 32'd0);
    chk("release.count", 32'(count), 32'd4);
    accepted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) begin
        step();
        accepted = 1'b1;
        break;
      end
      chk($sformatf("blocked%0d.count", i), 32'(count), 32'd4);
      step();
    end
    chk("fifth.accepted", 32'(accepted), 32'd1);
    chk("fifth.count", 32'(count), 32'd4);
    in_valid = 1'b0; in_isst = 1'b0;
    g = 0;
    while (count != 4'd0 && g < 60) begin step(); g++; end
    chk("full.drained", 32'(count), 32'd0);
    repeat (3) step();

    // Reset while a load waits for memory.
    push(1'b1, 1'b0, 16'h0400, 16'h0040, 16'h0000);
    step();
    chk("rstwait.issue_isld", 32'(mem_isld), 32'd1);
    step();
    chk("rstwait.pre_count", 32'(count), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwait.in_ready", 32'(in_ready), 32'd1);
    chk("rstwait.count", 32'(count), 32'd0);
    chk("rstwait.mem_isld", 32'(mem_isld), 32'd0);
    chk("rstwait.wb_valid", 32'(wb_valid), 32'd0);
    chk("rstwait.wb_rdval", 32'(wb_rdval), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_wb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen_wb = seen_wb | wb_valid;
    end
    chk("rstwait.no_wb", 32'(seen_wb), 32'd0);

    // Nine mixed requests through the queue: issue order must equal push order.
    issued_q.delete();
    log_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_addr[i] = 16'(16'h0100 + i);
      in_valid = 1'b1; in_isld = (i % 3 != 0); in_isst = (i % 3 == 0);
      in_instr = 16'(i << 8); in_addr = exp_addr[i]; in_data = 16'(16'hC000 + i);
      g = 0;
      while (!in_ready && g < 50) begin step(); g++; end
      if (g >= 50) chk($sformatf("order.push%0d_timeout", i), 32'd1, 32'd0);
      step();
    end
    in_valid = 1'b0; in_isld = 1'b0; in_isst = 1'b0;
    g = 0;
    while ((count != 4'd0 || wb_valid) && g < 100) begin step(); g++; end
    repeat (2) step();
    log_en = 1'b0;
    chk("order.n_issued", 32'(issued_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("order.addr%0d", i), (i < issued_q.size()) ? 32'(issued_q[i]) : 32'hFFFF_FFFF,
          32'(exp_addr[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
